// File: rtl/bus_write_arbiter.sv
// Round-robin arbiter for two write masters onto the peripheral write bus.
// It holds one registered write in flight and drops unmapped or stalled writes with an error pulse.
module bus_write_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_dout,
   input  logic        m0_write_valid,
   output logic        m0_write_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_dout,
   input  logic        m1_write_valid,
   output logic        m1_write_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_dout,
   output logic [3:0]  s_sel,
   output logic        s_write_valid,
   input  logic [3:0]  s_write_ready,
   output logic        err_unmapped,
   output logic        err_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_last_grant;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_addr;
   logic [31:0]        r_dout;
   logic               r_err_unmapped;
   logic               r_err_timeout;

   logic               w_grant_m1;
   logic               w_accept;
   logic [31:0]        w_addr;
   logic [31:0]        w_dout;
   logic               w_mapped;
   logic               w_slot_done;
   logic               w_drop;
   logic [3:0]         w_sel;

   // On a tie the master that did not win last time gets the bus.
   always_comb begin
      w_grant_m1  = m1_write_valid && (!m0_write_valid || !r_last_grant);
      w_addr      = w_grant_m1 ? m1_addr : m0_addr;
      w_dout      = w_grant_m1 ? m1_dout : m0_dout;
      w_mapped    = (w_addr[31:28] == 4'hE);
      w_slot_done = s_write_ready[r_addr[27:26]];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         IDLE: begin
            w_accept = !reset && (m0_write_valid || m1_write_valid);
            if (w_accept && w_mapped) w_state_nxt = BUSY;
         end
         BUSY: begin
            if (w_slot_done) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == '0) begin
               w_drop      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_last_grant   <= 1'b1;
         r_cnt          <= '0;
         r_addr         <= '0;
         r_dout         <= '0;
         r_err_unmapped <= 1'b0;
         r_err_timeout  <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_err_unmapped <= w_accept && !w_mapped;
         r_err_timeout  <= w_drop;
         if (w_accept) begin
            r_last_grant <= w_grant_m1;
            if (w_mapped) begin
               r_addr <= w_addr;
               r_dout <= w_dout;
               r_cnt  <= CNT_W'(TIMEOUT);
            end
         end else if (r_state == BUSY && !w_slot_done && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_sel = 4'b0000;
      if (r_state == BUSY) w_sel[r_addr[27:26]] = 1'b1;
   end

   assign m0_write_ready = w_accept && !w_grant_m1;
   assign m1_write_ready = w_accept &&  w_grant_m1;
   assign s_addr         = r_addr;
   assign s_dout         = r_dout;
   assign s_sel          = w_sel;
   assign s_write_valid  = (r_state == BUSY);
   assign err_unmapped   = r_err_unmapped;
   assign err_timeout    = r_err_timeout;

endmodule
